// File: rtl/updown_sweep_ctrl.sv
// Sequencer for an up/down counter: clears it, seeks to a low limit, then runs
// N triangular sweeps between low and high limits. Optional UPDOWN_SWEEP_DWELL_EN
// adds a programmable turnaround dwell.
module updown_sweep_ctrl #(
    parameter int CW = 5,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] lo_lim,
    input  logic [CW-1:0] hi_lim,
    input  logic [SW-1:0] sweeps,
`ifdef UPDOWN_SWEEP_DWELL_EN
    input  logic [3:0]    dwell,
`endif
    input  logic [CW-1:0] count,
    output logic          up_down,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [SW-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEEK,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] lo_reg;
    logic [CW-1:0] hi_reg;
    logic [SW-1:0] sweeps_reg;
    logic [SW-1:0] sweep_cnt_reg;
    logic [SW-1:0] sweep_next;
    logic          err_reg;
    logic          at_lo;
    logic          at_hi;
    logic          start_ok;
    logic          turn_ok;

    assign at_lo      = (count == lo_reg);
    assign at_hi      = (count == hi_reg);
    assign start_ok   = (lo_lim < hi_lim) && (sweeps != '0);
    assign sweep_next = sweep_cnt_reg + SW'(1);

`ifdef UPDOWN_SWEEP_DWELL_EN
    logic [3:0] dwell_reg;
    logic [3:0] dcnt_reg;

    // A turnaround completes once the limit has been held for dwell+1 cycles.
    assign turn_ok = (dcnt_reg == dwell_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_reg <= '0;
            dcnt_reg  <= '0;
        end else begin
            if (state_reg == S_IDLE && start && !abort && start_ok) begin
                dwell_reg <= dwell;
            end
            if (abort || ((state_reg == S_UP || state_reg == S_DOWN) && turn_ok)) begin
                dcnt_reg <= '0;
            end else if ((state_reg == S_UP && at_hi) || (state_reg == S_DOWN && at_lo)) begin
                dcnt_reg <= dcnt_reg + 4'd1;
            end
        end
    end
`else
    assign turn_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            lo_reg        <= '0;
            hi_reg        <= '0;
            sweeps_reg    <= '0;
            sweep_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (abort) begin
                // Abort also swallows a start presented in the same cycle.
                state_reg <= S_IDLE;
            end else begin
                unique case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                lo_reg        <= lo_lim;
                                hi_reg        <= hi_lim;
                                sweeps_reg    <= sweeps;
                                sweep_cnt_reg <= '0;
                                state_reg     <= S_CLEAR;
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: state_reg <= S_SEEK;
                    S_SEEK: begin
                        if (at_lo) state_reg <= S_UP;
                    end
                    S_UP: begin
                        if (at_hi && turn_ok) state_reg <= S_DOWN;
                    end
                    S_DOWN: begin
                        if (at_lo && turn_ok) begin
                            sweep_cnt_reg <= sweep_next;
                            state_reg     <= (sweep_next == sweeps_reg) ? S_DONE : S_UP;
                        end
                    end
                    S_DONE:  state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        up_down = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_reg)
            S_CLEAR: begin
                cnt_clr = 1'b1;
                busy    = 1'b1;
            end
            S_SEEK: begin
                up_down = 1'b1;
                cnt_en  = !at_lo;
                busy    = 1'b1;
            end
            S_UP: begin
                up_down = 1'b1;
                cnt_en  = !at_hi;
                busy    = 1'b1;
            end
            S_DOWN: begin
                cnt_en  = !at_lo;
                busy    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign err       = err_reg;
    assign sweep_cnt = sweep_cnt_reg;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Closed-loop bench: a behavioural counter driven by the controller, checked
// cycle by cycle against a trajectory built from the sweep rules.
module tb_updown_sweep_ctrl;

    typedef struct packed {
        logic [4:0] count;
        logic       ud;
        logic       en;
        logic       clr;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] sw;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] lo_lim;
    logic [4:0] hi_lim;
    logic [3:0] sweeps;
    logic [4:0] cnt;
    logic       up_down;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_cnt;
`ifdef UPDOWN_SWEEP_DWELL_EN
    logic [3:0] dwell;
    localparam int DMAX = 3;
`else
    localparam int DMAX = 0;
`endif

    int   tests;
    int   fails;
    int   run_id;
    int   last_sw;
    rec_t exp_q[$];
    int   ph_q[$];

    updown_sweep_ctrl #(.CW(5), .SW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .lo_lim    (lo_lim),
        .hi_lim    (hi_lim),
        .sweeps    (sweeps),
`ifdef UPDOWN_SWEEP_DWELL_EN
        .dwell     (dwell),
`endif
        .count     (cnt),
        .up_down   (up_down),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .sweep_cnt (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath under control; deliberately not touched by reset.
    initial cnt = 5'd7;
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= 5'd0;
        else if (cnt_en) cnt <= up_down ? cnt + 5'd1 : cnt - 5'd1;
    end

    function automatic rec_t obs();
        return {cnt, up_down, cnt_en, cnt_clr, busy, done, err, sweep_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input rec_t o, input rec_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input int ph, input int c, input bit ud, input bit en,
                        input bit clr, input bit bz, input bit dn, input int sw);
        rec_t r;
        r.count = 5'(c);
        r.ud    = ud;
        r.en    = en;
        r.clr   = clr;
        r.busy  = bz;
        r.done  = dn;
        r.err   = 1'b0;
        r.sw    = 4'(sw);
        exp_q.push_back(r);
        ph_q.push_back(ph);
    endtask

    // Expected per-cycle trajectory from the accepting edge to the DONE cycle.
    task automatic build(input int c0, input int lo, input int hi, input int n, input int d);
        exp_q.delete();
        ph_q.delete();
        push(0, c0, 0, 0, 1, 1, 0, 0);
        for (int v = 0; v <= lo; v++) push(1, v, 1, v != lo, 0, 1, 0, 0);
        for (int s = 0; s < n; s++) begin
            for (int v = lo; v < hi; v++)  push(2, v, 1, 1, 0, 1, 0, s);
            for (int i = 0; i <= d; i++)   push(2, hi, 1, 0, 0, 1, 0, s);
            for (int v = hi; v > lo; v--)  push(3, v, 0, 1, 0, 1, 0, s);
            for (int i = 0; i <= d; i++)   push(3, lo, 0, 0, 0, 1, 0, s);
        end
        push(4, lo, 0, 0, 0, 0, 1, n);
    endtask

    // mode 0: full run, 1: abort mid-DOWN, 2: async reset mid-UP
    task automatic run(input int lo, input int hi, input int n, input int d, input int mode);
        int   stop_at;
        int   cand[$];
        rec_t e;
        run_id++;
        build(int'(cnt), lo, hi, n, d);
        stop_at = -1;
        if (mode != 0) begin
            foreach (ph_q[i]) if (ph_q[i] == (mode == 1 ? 3 : 2) && exp_q[i].en) cand.push_back(i);
            stop_at = cand[$urandom_range(0, cand.size() - 1)];
        end
        lo_lim = 5'(lo);
        hi_lim = 5'(hi);
        sweeps = 4'(n);
`ifdef UPDOWN_SWEEP_DWELL_EN
        dwell  = 4'(d);
`endif
        start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            step();
            check($sformatf("run%0d_cyc%0d", run_id, k), obs(), exp_q[k]);
            // Mid-run input churn, including starts while busy, must be ignored.
            start  = 1'($urandom_range(0, 1));
            lo_lim = 5'($urandom);
            hi_lim = 5'($urandom);
            sweeps = 4'($urandom);
`ifdef UPDOWN_SWEEP_DWELL_EN
            dwell  = 4'($urandom);
`endif
            if (k == stop_at) begin
                start = 1'b0;
                e = '0;
                if (mode == 1) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    e.count = exp_q[k].count - 5'd1;
                    e.sw    = exp_q[k].sw;
                    check($sformatf("run%0d_abort", run_id), obs(), e);
                    step();
                    check($sformatf("run%0d_abort_hold", run_id), obs(), e);
                    last_sw = int'(exp_q[k].sw);
                end else begin
                    #2 reset = 1'b1;
                    #1;
                    e.count = exp_q[k].count;
                    check($sformatf("run%0d_async_reset", run_id), obs(), e);
                    #1 reset = 1'b0;
                    step();
                    check($sformatf("run%0d_reset_idle", run_id), obs(), e);
                    last_sw = 0;
                end
                return;
            end
        end
        start = 1'b0;
        step();
        e = '0;
        e.count = 5'(lo);
        e.sw    = 4'(n);
        check($sformatf("run%0d_idle", run_id), obs(), e);
        last_sw = n;
    endtask

    task automatic reject(input int lo, input int hi, input int n, input bit with_abort);
        rec_t e;
        e = '0;
        e.count = cnt;
        e.sw    = 4'(last_sw);
        lo_lim = 5'(lo);
        hi_lim = 5'(hi);
        sweeps = 4'(n);
        start  = 1'b1;
        abort  = with_abort;
        step();
        start  = 1'b0;
        abort  = 1'b0;
        e.err  = !with_abort;
        check($sformatf("reject_%0d_%0d_%0d_%0d", lo, hi, n, with_abort), obs(), e);
        step();
        e.err  = 1'b0;
        check($sformatf("reject_after_%0d_%0d_%0d_%0d", lo, hi, n, with_abort), obs(), e);
    endtask

    initial begin
        rec_t e;
        int   lo;
        int   hi;
        tests   = 0;
        fails   = 0;
        run_id  = 0;
        last_sw = 0;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        lo_lim  = '0;
        hi_lim  = '0;
        sweeps  = '0;
`ifdef UPDOWN_SWEEP_DWELL_EN
        dwell   = '0;
`endif
        #1;
        e = '0;
        e.count = 5'd7;
        check("reset_state", obs(), e);
        @(negedge clk);
        reset = 1'b0;

        run(2, 5, 1, 0, 0);
        run(0, 3, 3, 0, 0);

        reject(6, 6, 2, 1'b0);
        reject(3, 9, 0, 1'b0);
        reject(9, 4, 1, 1'b0);
        reject(1, 4, 2, 1'b1);

        for (int i = 0; i < 4; i++) begin
            lo = $urandom_range(0, 30);
            hi = $urandom_range(lo + 1, 31);
            run(lo, hi, $urandom_range(1, 3), $urandom_range(0, DMAX), 0);
        end

        lo = $urandom_range(0, 20);
        run(lo, lo + $urandom_range(2, 10), 2, $urandom_range(0, DMAX), 1);
        run(1, 4, 1, 0, 0);
        lo = $urandom_range(0, 20);
        run(lo, lo + $urandom_range(2, 10), 2, $urandom_range(0, DMAX), 2);
        run(3, 6, 2, 0, 0);

        run(0, 31, 1, 0, 0);
        run(0, 1, 15, 0, 0);
`ifdef UPDOWN_SWEEP_DWELL_EN
        run(1, 3, 1, 2, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
